// File: rtl/font_rom_scheduler.sv
// font_rom_scheduler
//
// Shares one synchronous font ROM between the text display path and an
// auxiliary (debug/readback) requester. The display fetch for the next
// character cell is issued on the trigger edge with no arbitration delay. The
// fetched glyph row is double-buffered (next_word -> active_word), so the pixel
// path changes words exactly on the cell boundary. Auxiliary reads use the
// remaining ROM slots and complete through a req/ack handshake.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   pixel_tick, pixel_x   pixel enable and current column (advances on tick edge)
//   video_on              visible-area flag for the current pixel
//   fetch_en              next cell is visible (lookahead)
//   disp_char, disp_row   glyph address of the next cell (lookahead)
//   aux_req, aux_addr     auxiliary read request/address (held until ack)
//   aux_ack, aux_data     one-cycle ack pulse; read result held until next ack
//   rom_addr, rom_data    ROM address (registered) and data (one clock later)
//   font_bit              current pixel bit towards the colour mux
module font_rom_scheduler #(
  parameter int CHAR_W = 7,
  parameter int ROW_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pixel_tick,
  input  logic [9:0]              pixel_x,
  input  logic                    video_on,
  input  logic                    fetch_en,
  input  logic [CHAR_W-1:0]       disp_char,
  input  logic [ROW_W-1:0]        disp_row,
  input  logic                    aux_req,
  input  logic [CHAR_W+ROW_W-1:0] aux_addr,
  output logic                    aux_ack,
  output logic [DATA_W-1:0]       aux_data,
  output logic [CHAR_W+ROW_W-1:0] rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic                    font_bit
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_AUX  = 2'd2
  } tag_t;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_WAIT = 2'd1,
    A_ACK  = 2'd2
  } aux_state_t;

  tag_t              tag_p0;
  tag_t              tag_p1;
  aux_state_t        aux_state;
  logic [DATA_W-1:0] next_word;
  logic [DATA_W-1:0] active_word;

  logic cell_pos6;
  logic disp_trig;
  logic blank_trig;
  logic swap;
  logic aux_issue;

  // Only the position within the 8-pixel cell matters here.
  logic unused_px;
  assign unused_px = ^pixel_x[9:3];

  assign cell_pos6  = pixel_tick & (pixel_x[2:0] == 3'b110);
  assign disp_trig  = cell_pos6 & fetch_en;
  assign blank_trig = cell_pos6 & ~fetch_en;
  assign swap       = pixel_tick & (pixel_x[2:0] == 3'b111);

  // Display owns the slot on its trigger edge; a colliding aux read waits one cycle.
  assign aux_issue  = (aux_state == A_IDLE) & aux_req & ~disp_trig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr    <= '0;
      tag_p0      <= TAG_NONE;
      tag_p1      <= TAG_NONE;
      next_word   <= '0;
      active_word <= '0;
      aux_data    <= '0;
      aux_ack     <= 1'b0;
      aux_state   <= A_IDLE;
    end else begin
      // Stage p0: issue slot, ROM address and tag launched together
      if (disp_trig) begin
        rom_addr <= {disp_char, disp_row};
        tag_p0   <= TAG_DISP;
      end else if (aux_issue) begin
        rom_addr <= aux_addr;
        tag_p0   <= TAG_AUX;
      end else begin
        tag_p0   <= TAG_NONE;
      end

      // Stage p1: ROM is reading the address; tag follows it
      tag_p1 <= tag_p0;

      // Stage p2: ROM data valid, route it by tag
      if (tag_p1 == TAG_DISP) begin
        next_word <= rom_data;
      end else if (blank_trig) begin
        // No fetch for an invisible cell: stage a blank word for the swap.
        next_word <= '0;
      end

      if (tag_p1 == TAG_AUX) begin
        aux_data <= rom_data;
      end

      if (swap) begin
        active_word <= next_word;
      end

      aux_ack <= 1'b0;
      case (aux_state)
        A_IDLE: if (aux_issue) aux_state <= A_WAIT;
        A_WAIT: if (tag_p1 == TAG_AUX) begin
          aux_state <= A_ACK;
          aux_ack   <= 1'b1;
        end
        A_ACK:  aux_state <= A_IDLE;
        default: aux_state <= A_IDLE;
      endcase
    end
  end

  // ~x equals 7-x for a 3-bit index: MSB of the word is the leftmost pixel.
  assign font_bit = video_on & active_word[~pixel_x[2:0]];

endmodule

// File: tb/tb_font_rom_scheduler.sv
module tb_font_rom_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pixel_tick;
  logic [9:0]  pixel_x;
  logic        video_on;
  logic        fetch_en;
  logic [6:0]  disp_char;
  logic [3:0]  disp_row;
  logic        aux_req;
  logic [10:0] aux_addr;
  logic        aux_ack;
  logic [7:0]  aux_data;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        font_bit;

  logic [7:0]  mem [0:2047];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  font_rom_scheduler #(.CHAR_W(7), .ROW_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_tick(pixel_tick), .pixel_x(pixel_x),
    .video_on(video_on), .fetch_en(fetch_en), .disp_char(disp_char),
    .disp_row(disp_row), .aux_req(aux_req), .aux_addr(aux_addr),
    .aux_ack(aux_ack), .aux_data(aux_data), .rom_addr(rom_addr),
    .rom_data(rom_data), .font_bit(font_bit)
  );

  // Synchronous font ROM: data one clock after the address edge.
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Behavioural reference: glyph words come straight from mem at the trigger,
  // an aux read is granted when the requester is idle and the slot is not
  // taken by display, acks two edges after the grant, and the requester is
  // busy for three edges after the grant.
  logic [10:0] m_addr, m_aaddr;
  logic [7:0]  m_cur, m_next, m_adata;
  bit          m_busy, m_ack, m_t;
  int          m_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_addr = '0; m_cur = '0; m_next = '0; m_adata = '0;
      m_busy = 0; m_ack = 0; m_cnt = 0; m_aaddr = '0;
    end else begin
      m_t = pixel_tick && fetch_en && (pixel_x[2:0] == 3'd6);
      if (pixel_tick && pixel_x[2:0] == 3'd7) m_cur = m_next;
      if (pixel_tick && pixel_x[2:0] == 3'd6)
        m_next = fetch_en ? mem[{disp_char, disp_row}] : 8'h00;
      m_ack = 0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == 2) begin
          m_ack   = 1;
          m_adata = mem[m_aaddr];
        end else if (m_cnt == 3) begin
          m_busy = 0;
        end
      end else if (aux_req && !m_t) begin
        m_busy  = 1;
        m_cnt   = 0;
        m_aaddr = aux_addr;
        m_addr  = aux_addr;
      end
      if (m_t) m_addr = {disp_char, disp_row};
    end
    #1;
    chk("model_rom_addr", 32'(rom_addr), 32'(m_addr));
    chk("model_aux_ack",  32'(aux_ack),  32'(m_ack));
    chk("model_aux_data", 32'(aux_data), 32'(m_adata));
    chk("model_font_bit", 32'(font_bit), 32'(video_on & m_cur[3'd7 - pixel_x[2:0]]));
  end

  // Stimulus state
  bit run_pix   = 0;
  bit rand_mode = 0;
  int clk_per_tick = 4;
  int phase_c = 0;

  task automatic cyc();
    @(negedge clk);
    if (pixel_tick) pixel_x = (pixel_x == 10'd799) ? 10'd0 : pixel_x + 10'd1;
    if (run_pix) begin
      if (phase_c >= clk_per_tick - 1) begin
        pixel_tick = 1'b1;
        phase_c = 0;
        if (rand_mode) clk_per_tick = $urandom_range(3, 5);
      end else begin
        pixel_tick = 1'b0;
        phase_c++;
      end
    end else begin
      pixel_tick = 1'b0;
    end
    if (rand_mode) begin
      disp_char = 7'($urandom);
      disp_row  = 4'($urandom);
      fetch_en  = ($urandom % 4) != 0;
      video_on  = ($urandom % 8) != 0;
      if (aux_req && aux_ack) begin
        if ($urandom % 2) aux_req = 1'b0;
        else aux_addr = 11'($urandom);
      end else if (!aux_req && ($urandom % 3 == 0)) begin
        aux_req  = 1'b1;
        aux_addr = 11'($urandom);
      end
    end
  endtask

  task automatic wait_x(input int k);
    int g = 0;
    while (pixel_x[2:0] != 3'(k) && g < 200) begin
      cyc();
      g++;
    end
    if (g >= 200) timeout("wait_x");
  endtask

  task automatic wait_trig();
    int g = 0;
    do begin
      cyc();
      g++;
    end while (!(pixel_tick && pixel_x[2:0] == 3'd6) && g < 200);
    if (g >= 200) timeout("wait_trig");
  endtask

  bit pat [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  int first, n_ack;
  logic [7:0] lit_data;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    mem[11'h413] = 8'hA5;
    mem[11'h123] = 8'h3C;

    // Reset with requests and pixel ticks active
    rst_n = 1'b0; pixel_tick = 1'b1; pixel_x = '0; video_on = 1'b1; fetch_en = 1'b1;
    disp_char = 7'h41; disp_row = 4'h3; aux_req = 1'b1; aux_addr = 11'h123;
    repeat (2) @(negedge clk);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_aux_ack",  32'(aux_ack),  32'h0);
    chk("rst_font_bit", 32'(font_bit), 32'h0);
    rst_n = 1'b1; aux_req = 1'b0; pixel_tick = 1'b0;

    // Uncontested aux read
    aux_req = 1'b1; aux_addr = 11'h123; first = 0; n_ack = 0; lit_data = '0;
    for (int n = 1; n <= 6; n++) begin
      cyc();
      if (aux_ack) begin
        n_ack++;
        if (first == 0) first = n;
        lit_data = aux_data;
        aux_req = 1'b0;
      end
    end
    chk("aux_latency", 32'(first), 32'd3);
    chk("aux_once",    32'(n_ack), 32'd1);
    chk("aux_data",    32'(lit_data), 32'h3C);

    // Display cell: address at trigger, then glyph row 8'hA5 across the next cell
    run_pix = 1; clk_per_tick = 4; phase_c = 0; pixel_x = '0;
    wait_trig();
    @(posedge clk); #1;
    chk("disp_addr", 32'(rom_addr), 32'h413);
    for (int k = 0; k < 8; k++) begin
      wait_x(k);
      #1;
      chk("disp_bit", 32'(font_bit), 32'(pat[k]));
    end
    video_on = 1'b0; #1;
    chk("video_off", 32'(font_bit), 32'h0);
    video_on = 1'b1;

    // Blank cell: fetch_en low at the next cell's trigger
    fetch_en = 1'b0;
    wait_x(1);
    wait_x(0);
    #1;
    chk("blank_cell", 32'(font_bit), 32'h0);
    fetch_en = 1'b1;

    // Collision: aux request raised in the trigger cycle
    wait_trig();
    aux_req = 1'b1; aux_addr = 11'h123; first = 0; lit_data = '0;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      if (n == 1) chk("coll_disp_addr", 32'(rom_addr), 32'h413);
      if (n == 2) chk("coll_aux_addr",  32'(rom_addr), 32'h123);
      if (aux_ack && first == 0) begin
        first = n;
        lit_data = aux_data;
        aux_req = 1'b0;
      end
    end
    chk("coll_latency", 32'(first), 32'd4);
    chk("coll_data",    32'(lit_data), 32'h3C);

    // Reset while the aux read is in flight
    run_pix = 0;
    cyc();
    aux_req = 1'b1; aux_addr = 11'h123;
    cyc();
    rst_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      cyc();
      chk("rst_mid_noack", 32'(aux_ack), 32'h0);
    end
    rst_n = 1'b1; first = 0; lit_data = '0;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      if (aux_ack && first == 0) begin
        first = n;
        lit_data = aux_data;
        aux_req = 1'b0;
      end
    end
    chk("rst_mid_latency", 32'(first), 32'd3);
    chk("rst_mid_data",    32'(lit_data), 32'h3C);

    // Randomized traffic across a line wrap, with one reset pulse
    rand_mode = 1; run_pix = 1; pixel_x = 10'd770; phase_c = 0;
    for (int i = 0; i < 6000; i++) begin
      cyc();
      if (i == 3000) rst_n = 1'b0;
      if (i == 3003) rst_n = 1'b1;
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
